// File: rtl/pmem_reader_pkg.sv
// Shared definitions for the pmem read-back path: FSM states, core-level
// widths and where this block's pmem controls sit in the core instruction word.
package pmem_reader_pkg;

    localparam int BW_PSUM    = 20;
    localparam int COL        = 8;
    localparam int PMEM_ADD_W = 4;

    localparam int INST_W            = 34;
    localparam int INST_PMEM_RD_BIT  = 1;
    localparam int INST_PMEM_ADD_LSB = 8;
    localparam int INST_PMEM_ADD_MSB = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Overlays this block's pmem read controls onto a core instruction word,
    // used while the reader owns the pmem port.
    function automatic logic [INST_W-1:0] pmem_inst_overlay(
        input logic [INST_W-1:0]     inst,
        input logic                  rd,
        input logic [PMEM_ADD_W-1:0] add
    );
        logic [INST_W-1:0] r;
        r = inst;
        r[INST_PMEM_RD_BIT] = rd;
        r[INST_PMEM_ADD_MSB:INST_PMEM_ADD_LSB] = add;
        return r;
    endfunction

endpackage

// File: rtl/pmem_reader_if.sv
// Psum output stream of the pmem reader: one psum per beat with its column
// index and an end-of-range marker.
interface pmem_reader_if
    import pmem_reader_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int col     = COL
) ();

    localparam int COL_W = (col > 1) ? $clog2(col) : 1;

    // A beat transfers on a rising clock edge where out_valid && out_ready.
    // The master holds out_data/out_col/out_last stable while out_valid is high
    // and out_ready is low; out_valid never drops without a transfer except in reset.
    logic               out_valid;
    logic               out_ready;
    logic [bw_psum-1:0] out_data;
    logic [COL_W-1:0]   out_col;
    logic               out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_col,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/pmem_reader.sv
// Reads a programmable range of psum rows out of pmem and serialises each row
// onto a valid/ready stream, column 0 first. All outputs come straight from flops.
module pmem_reader
    import pmem_reader_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int col     = COL,
    parameter int add_w   = PMEM_ADD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [add_w-1:0]       base_add,
    input  logic [add_w:0]         len,
    output logic                   pmem_rd,
    output logic [add_w-1:0]       pmem_add,
    input  logic [col*bw_psum-1:0] pmem_out,
    pmem_reader_if.master          strm,
    output logic                   busy,
    output logic                   done,
    output state_t                 state_dbg
);

    localparam int               COL_W    = (col > 1) ? $clog2(col) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(col - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [add_w:0]   ROW_ONE  = (add_w + 1)'(1);

    state_t                 state_q, state_d;
    logic [add_w:0]         row_q, row_d;
    logic [COL_W-1:0]       c_q, c_d;
    logic [add_w-1:0]       base_q, base_d;
    logic [add_w:0]         len_q, len_d;
    logic [col*bw_psum-1:0] row_buf_q, row_buf_d;

    logic                   pmem_rd_q, pmem_rd_d;
    logic [add_w-1:0]       pmem_add_q, pmem_add_d;
    logic                   out_valid_q, out_valid_d;
    logic [bw_psum-1:0]     out_data_q, out_data_d;
    logic [COL_W-1:0]       out_col_q, out_col_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            c_q         <= '0;
            base_q      <= '0;
            len_q       <= '0;
            row_buf_q   <= '0;
            pmem_rd_q   <= 1'b0;
            pmem_add_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            c_q         <= c_d;
            base_q      <= base_d;
            len_q       <= len_d;
            row_buf_q   <= row_buf_d;
            pmem_rd_q   <= pmem_rd_d;
            pmem_add_q  <= pmem_add_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        c_d       = c_q;
        base_d    = base_q;
        len_d     = len_q;
        row_buf_d = row_buf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        base_d  = base_add;
                        len_d   = len;
                        row_d   = '0;
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                row_buf_d = pmem_out;
                c_d       = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                // out_valid is always high in SHIFT, so ready alone marks a transfer.
                if (strm.out_ready) begin
                    if (c_q == COL_LAST) begin
                        row_d   = row_q + ROW_ONE;
                        state_d = (row_d < len_q) ? ST_RD : ST_FIN;
                    end else begin
                        c_d = c_q + COL_ONE;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it after the edge.
        pmem_rd_d   = (state_d == ST_RD);
        pmem_add_d  = (state_d == ST_RD) ? (base_d + row_d[add_w-1:0]) : pmem_add_q;
        out_valid_d = (state_d == ST_SHIFT);
        out_data_d  = (state_d == ST_SHIFT) ? row_buf_d[int'(c_d)*bw_psum +: bw_psum] : out_data_q;
        out_col_d   = (state_d == ST_SHIFT) ? c_d : out_col_q;
        out_last_d  = (state_d == ST_SHIFT) && (c_d == COL_LAST) && (row_d == (len_d - ROW_ONE));
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
    end

    assign pmem_rd        = pmem_rd_q;
    assign pmem_add       = pmem_add_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_col   = out_col_q;
    assign strm.out_last  = out_last_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_pmem_reader.sv
// Randomised bench for pmem_reader: a behavioural pmem plus a reference model
// that lists every expected address and beat of a read range up front.
module tb_pmem_reader;
    import pmem_reader_pkg::*;

    localparam int W      = BW_PSUM;
    localparam int RW     = COL * BW_PSUM;
    localparam int CW     = $clog2(COL);
    localparam int BEAT_W = 1 + CW + W;
    localparam int ROWS   = 1 << PMEM_ADD_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                  start;
    logic [PMEM_ADD_W-1:0] base_add;
    logic [PMEM_ADD_W:0]   len;
    logic                  pmem_rd;
    logic [PMEM_ADD_W-1:0] pmem_add;
    logic [RW-1:0]         pmem_out;
    logic                  busy;
    logic                  done;
    state_t                state_dbg;

    pmem_reader_if #(.bw_psum(W), .col(COL)) strm ();

    pmem_reader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_add (base_add),
        .len      (len),
        .pmem_rd  (pmem_rd),
        .pmem_add (pmem_add),
        .pmem_out (pmem_out),
        .strm     (strm),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // Behavioural pmem with one-cycle registered read.
    logic [W-1:0] mem [ROWS][COL];
    always @(posedge clk) begin
        if (pmem_rd) begin
            for (int c = 0; c < COL; c++) pmem_out[c*W +: W] <= mem[pmem_add][c];
        end
    end

    // ---------------- scoreboard ----------------
    logic [BEAT_W-1:0]     exp_q[$];
    logic [PMEM_ADD_W-1:0] add_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rd_count = 0;
    int done_count = 0;
    int ready_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stream sink: ready changes 1 ns after each rising edge.
    initial begin
        int phase;
        phase = 0;
        strm.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       strm.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    strm.out_ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                default: strm.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples on the falling edge, mid-cycle.
    initial begin
        logic [BEAT_W-1:0] e;
        logic [31:0]       held_val;
        logic              held;
        logic              done_due;
        held = 1'b0;
        done_due = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (pmem_rd) begin
                    rd_count++;
                    if (add_q.size() == 0) check("rd_extra", add_q.size(), 1);
                    else check("pmem_add", pmem_add, add_q.pop_front());
                end
                if (done) done_count++;
                if (done_due) check("done_after_last", done, 1'b1);
                done_due = 1'b0;
                if (held) begin
                    check("stall_valid", strm.out_valid, 1'b1);
                    check("stall_hold", {strm.out_last, strm.out_col, strm.out_data}, held_val);
                end
                held = strm.out_valid && !strm.out_ready;
                held_val = {strm.out_last, strm.out_col, strm.out_data};
                if (strm.out_valid && strm.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("beat_extra", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", strm.out_data, e[W-1:0]);
                        check("out_col", strm.out_col, e[W +: CW]);
                        check("out_last", strm.out_last, e[BEAT_W-1]);
                        if (e[BEAT_W-1]) done_due = 1'b1;
                    end
                end
            end else begin
                held = 1'b0;
                done_due = 1'b0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model / drivers ----------------
    task automatic expect_range(input int b, input int l);
        for (int r = 0; r < l; r++) begin
            int a;
            a = (b + r) % ROWS;
            add_q.push_back(PMEM_ADD_W'(a));
            for (int c = 0; c < COL; c++) begin
                exp_q.push_back({(r == l - 1) && (c == COL - 1), CW'(c), mem[a][c]});
            end
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COL; c++) mem[r][c] = W'($urandom);
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COL; c++) mem[r][c] = W'(100 * r + c);
    endtask

    task automatic pulse_start(input int b, input int l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_add = PMEM_ADD_W'(b);
        len = (PMEM_ADD_W + 1)'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
        base_add = PMEM_ADD_W'($urandom);
        len = (PMEM_ADD_W + 1)'($urandom);
    endtask

    task automatic run_read(input int b, input int l, input int mode, input bit stray);
        int start_rd, start_done, lat, cyc;
        expect_range(b, l);
        start_rd = rd_count;
        start_done = done_count;
        ready_mode = mode;
        pulse_start(b, l);
        if (l == 0) begin
            @(negedge clk);
            check("len0_done", done, 1'b1);
        end else begin
            lat = 0;
            for (int i = 1; i <= 8 && lat == 0; i++) begin
                @(negedge clk);
                if (strm.out_valid) lat = i;
            end
            check("first_valid_latency", lat, 3);
        end
        if (stray) begin
            repeat (2) @(negedge clk);
            pulse_start((b + 5) % ROWS, 1);
        end
        cyc = 0;
        while (done_count == start_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check("done_count", done_count - start_done, 1);
        check("rd_pulses", rd_count - start_rd, l);
        check("beats_left", exp_q.size(), 0);
        check("adds_left", add_q.size(), 0);
        check("busy_after", busy, 1'b0);
        exp_q.delete();
        add_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int start_rd, start_done, cyc;
        reset = 1'b1;
        start = 1'b0;
        base_add = '0;
        len = '0;
        repeat (2) @(negedge clk);
        check("rst_pmem_rd", pmem_rd, 1'b0);
        check("rst_pmem_add", pmem_add, 0);
        check("rst_out_valid", strm.out_valid, 1'b0);
        check("rst_out_data", strm.out_data, 0);
        check("rst_out_col", strm.out_col, 0);
        check("rst_out_last", strm.out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", state_dbg, ST_IDLE);
        reset = 1'b0;

        // Single row with alternating-sign psums 1,-2,3,...,-8.
        fill_random();
        for (int c = 0; c < COL; c++) mem[2][c] = (c % 2 == 0) ? W'(c + 1) : W'(-(c + 1));
        run_read(2, 1, 0, 1'b0);

        // Wrapping sweep 14,15,0,1 over the 100*row+col pattern.
        fill_pattern();
        run_read(14, 4, 0, 1'b0);

        // Backpressure with ready 1,0,0 repeating.
        fill_random();
        run_read(6, 2, 2, 1'b0);

        // Empty range, then a stray start during a busy read.
        run_read(3, 0, 0, 1'b0);
        run_read(11, 3, 1, 1'b1);

        // Extreme psum values at both ends of a row.
        fill_random();
        mem[9][0] = 20'h7FFFF;
        mem[9][7] = 20'h80000;
        run_read(9, 1, 1, 1'b0);

        // Reset while the second row is being streamed.
        fill_random();
        expect_range(5, 3);
        start_rd = rd_count;
        start_done = done_count;
        ready_mode = 0;
        pulse_start(5, 3);
        cyc = 0;
        while (rd_count < start_rd + 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check("pre_reset_valid", strm.out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", strm.out_valid, 1'b0);
        check("midrst_pmem_rd", pmem_rd, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_state", state_dbg, ST_IDLE);
        exp_q.delete();
        add_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_done", done_count - start_done, 0);
        run_read(5, 3, 0, 1'b0);

        // Full 16-row range starting mid-memory.
        fill_random();
        run_read(7, 16, 1, 1'b0);

        // Random ranges and sink behaviour.
        for (int t = 0; t < 8; t++) begin
            fill_random();
            run_read($urandom_range(0, ROWS - 1), $urandom_range(1, ROWS), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
